skid_buffer: RTL

- Elastic valid/ready register stage placed directly downstream of the fixed-latency data pipeline.
- Adds backpressure so a consumer can stall without losing words.
- A two-entry skid structure keeps full throughput (one word per cycle) while both handshake outputs stay purely registered, which breaks the combinational ready path between producer and consumer.

---
 rtl/skid_buffer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//   Elastic valid/ready register stage with a two-entry skid. It sustains one
//   word per cycle, and both in_ready and out_valid come straight from flops,
//   so no combinational ready path runs between the producer and the consumer.
//
//   Optional feature macro: SKID_BUFFER_STATS_EN. When it is defined, the
//   stall_cnt port exists and counts stalled cycles, saturating at all-ones.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream word present on in_data
//   in_ready   : stage can accept a word (registered)
//   in_data    : upstream data word
//   out_valid  : out_data holds a valid word (registered)
//   out_ready  : downstream accepts the word this cycle
//   out_data   : word presented downstream (registered)
//   stall_cnt  : cycles with out_valid & !out_ready (SKID_BUFFER_STATS_EN only)
// -----------------------------------------------------------------------------
module skid_buffer #(
    parameter int WIDTH       = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef SKID_BUFFER_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    // The state is encoded as {out_valid, full}. Each handshake output is
    // therefore a flop bit (or its inverse), with no decode logic behind it.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             load_main, main_from_skid, load_skid;
    logic             accept, fire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Output decode (pure flop bits)
    always_comb begin
        out_valid = state_q[1];
        in_ready  = ~state_q[0];
        out_data  = main_q;
    end

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    // Next state and register load enables
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_main = 1'b1;           // pass-through at full rate
                end else if (accept) begin
                    load_skid = 1'b1;           // consumer stalled: park in skid
                    state_d   = FULL;
                end else if (fire) begin
                    state_d   = EMPTY;          // main keeps a stale value
                end
            end
            FULL: begin
                if (fire) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) main_q <= main_from_skid ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end

`ifdef SKID_BUFFER_STATS_EN
    // Saturating stall counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule
